// File: rtl/msx_cart_mapper.sv
// ASCII8/ASCII16 MegaROM mapper for one MSX cartridge slot with a request/ack read path to ROM storage.
// Define CART_SRAM_EN to let ASCII8 bank values with bit7 set map their 8 KB page to SRAM.
module msx_cart_mapper #(
  parameter int          MODE      = 0,
  parameter logic [7:0]  BANK_MASK = 8'hFF
) (
  input  logic        clk21m,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic        cpu_mreq,
  input  logic        slot_sel,
  output logic [7:0]  d_to_cpu,
  output logic        data_oe,
  output logic [20:0] mem_addr,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic [7:0]  mem_wdata,
  output logic        mem_sram,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, WREQ} state_t;

  state_t      state_q, state_d;
  logic [7:0]  bank_q [4];
  logic        wr_q, rd_q, abort_q, abort_d;
  logic        acc, window, wr_lvl, rd_win, wr_pulse, rd_pulse;
  logic        bank_we;
  logic [1:0]  bank_idx, page_idx;
  logic [7:0]  bank_raw, bank_b;
  logic [20:0] rom_addr, addr_d;
  logic        sram_hit;
  logic        rd_req_d, wr_req_d, oe_d, sram_d;
  logic [7:0]  dout_d, wdata_d;

  assign acc      = slot_sel & cpu_mreq;
  assign window   = (cpu_addr[15:14] == 2'b01) || (cpu_addr[15:14] == 2'b10);
  assign wr_lvl   = acc & cpu_wr;
  assign rd_win   = acc & cpu_rd & window;
  assign wr_pulse = wr_lvl & ~wr_q;
  assign rd_pulse = rd_win & ~rd_q & ~wr_lvl;

  // Page 0x4000/0x6000/0x8000/0xA000 maps to index 0..3 in ASCII8; ASCII16 uses cpu_addr[15] only.
  assign page_idx = (MODE == 0) ? {cpu_addr[15], cpu_addr[13]} : {1'b0, cpu_addr[15]};
  assign bank_raw = bank_q[page_idx];
  assign bank_b   = bank_raw & BANK_MASK;
  assign rom_addr = (MODE == 0) ? {bank_b, cpu_addr[12:0]} : {bank_b[6:0], cpu_addr[13:0]};

`ifdef CART_SRAM_EN
  assign sram_hit = (MODE == 0) && bank_raw[7];
`else
  assign sram_hit = 1'b0;
`endif

  always_comb begin
    bank_we  = 1'b0;
    bank_idx = cpu_addr[12:11];
    if (wr_pulse && cpu_addr[15:13] == 3'b011) begin
      if (MODE == 0) begin
        bank_we = 1'b1;
      end else if (!cpu_addr[11]) begin
        bank_we  = 1'b1;
        bank_idx = {1'b0, cpu_addr[12]};
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    abort_d  = abort_q;
    rd_req_d = mem_rd_req;
    wr_req_d = mem_wr_req;
    oe_d     = data_oe;
    dout_d   = d_to_cpu;
    addr_d   = mem_addr;
    sram_d   = mem_sram;
    wdata_d  = mem_wdata;
    case (state_q)
      IDLE: begin
        if (wr_pulse && sram_hit && cpu_addr[15:14] == 2'b10) begin
          state_d  = WREQ;
          wr_req_d = 1'b1;
          wdata_d  = cpu_dout;
          addr_d   = {8'h00, cpu_addr[12:0]};
          sram_d   = 1'b1;
        end else if (rd_pulse) begin
          state_d  = REQ;
          rd_req_d = 1'b1;
          abort_d  = 1'b0;
          addr_d   = sram_hit ? {8'h00, cpu_addr[12:0]} : rom_addr;
          sram_d   = sram_hit;
        end
      end
      REQ: begin
        // The request cannot be withdrawn once issued; a dropped read only discards the data.
        if (!(cpu_rd && acc)) abort_d = 1'b1;
        if (mem_ack) begin
          rd_req_d = 1'b0;
          if (abort_d) begin
            state_d = IDLE;
          end else begin
            oe_d    = 1'b1;
            dout_d  = mem_rdata;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!(cpu_rd && acc)) begin
          oe_d    = 1'b0;
          dout_d  = 8'hFF;
          state_d = IDLE;
        end
      end
      WREQ: begin
        if (mem_ack) begin
          wr_req_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      abort_q    <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      bank_q     <= '{default: 8'h00};
      d_to_cpu   <= 8'hFF;
      data_oe    <= 1'b0;
      mem_rd_req <= 1'b0;
      mem_wr_req <= 1'b0;
      mem_sram   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      abort_q    <= abort_d;
      wr_q       <= wr_lvl;
      rd_q       <= rd_win;
      if (bank_we) bank_q[bank_idx] <= cpu_dout;
      d_to_cpu   <= dout_d;
      data_oe    <= oe_d;
      mem_rd_req <= rd_req_d;
      mem_wr_req <= wr_req_d;
      mem_sram   <= sram_d;
      mem_addr   <= addr_d;
      mem_wdata  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_msx_cart_mapper.sv
// Directed bench for msx_cart_mapper: ASCII8, ASCII16 and masked-ASCII8 instances share one CPU bus.
module tb_msx_cart_mapper;

  logic        clk21m = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_wr, cpu_rd, cpu_mreq, slot_sel;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  logic [7:0]  d_a8, d_a16, d_msk, wd_a8, wd_a16, wd_msk;
  logic        oe_a8, oe_a16, oe_msk;
  logic [20:0] ad_a8, ad_a16, ad_msk;
  logic        rq_a8, rq_a16, rq_msk, wq_a8, wq_a16, wq_msk, sr_a8, sr_a16, sr_msk;

  int total = 0;
  int bad   = 0;

  always #5 clk21m = ~clk21m;

  msx_cart_mapper #(.MODE(0), .BANK_MASK(8'hFF)) u_a8 (
    .clk21m(clk21m), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_mreq(cpu_mreq), .slot_sel(slot_sel),
    .d_to_cpu(d_a8), .data_oe(oe_a8), .mem_addr(ad_a8), .mem_rd_req(rq_a8),
    .mem_wr_req(wq_a8), .mem_wdata(wd_a8), .mem_sram(sr_a8),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  msx_cart_mapper #(.MODE(1), .BANK_MASK(8'hFF)) u_a16 (
    .clk21m(clk21m), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_mreq(cpu_mreq), .slot_sel(slot_sel),
    .d_to_cpu(d_a16), .data_oe(oe_a16), .mem_addr(ad_a16), .mem_rd_req(rq_a16),
    .mem_wr_req(wq_a16), .mem_wdata(wd_a16), .mem_sram(sr_a16),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  msx_cart_mapper #(.MODE(0), .BANK_MASK(8'h0F)) u_msk (
    .clk21m(clk21m), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_mreq(cpu_mreq), .slot_sel(slot_sel),
    .d_to_cpu(d_msk), .data_oe(oe_msk), .mem_addr(ad_msk), .mem_rd_req(rq_msk),
    .mem_wr_req(wq_msk), .mem_wdata(wd_msk), .mem_sram(sr_msk),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_dout = d; cpu_mreq = 1'b1; cpu_wr = 1'b1;
    @(negedge clk21m);
    cpu_wr = 1'b0; cpu_mreq = 1'b0;
    @(negedge clk21m);
  endtask

  // Returns one negedge after the edge that raised mem_rd_req.
  task automatic rd_begin(input logic [15:0] a);
    cpu_addr = a; cpu_mreq = 1'b1; cpu_rd = 1'b1;
    @(negedge clk21m);
  endtask

  // Ack lands in the second request cycle; returns one negedge after the ack edge.
  task automatic ack_second(input logic [7:0] d);
    @(negedge clk21m);
    mem_ack = 1'b1; mem_rdata = d;
    @(negedge clk21m);
    mem_ack = 1'b0;
  endtask

  task automatic rd_end();
    cpu_rd = 1'b0; cpu_mreq = 1'b0;
    @(negedge clk21m);
  endtask

  initial begin
    reset_n = 1'b0; cpu_addr = '0; cpu_dout = '0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    cpu_mreq = 1'b0; slot_sel = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk21m);
    chk("rst_d", d_a8, 8'hFF);
    chk("rst_oe", oe_a8, 0);
    chk("rst_rq", rq_a8, 0);
    chk("rst_wq", wq_a8, 0);
    chk("rst_sram", sr_a8, 0);
    chk("rst_addr", ad_a8, 0);
    chk("rst_wdata", wd_a8, 0);
    reset_n = 1'b1;
    @(negedge clk21m);

    // Basic read of 0x4000 with bank 0
    rd_begin(16'h4000);
    chk("r0_rq", rq_a8, 1);
    chk("r0_addr", ad_a8, 21'h000000);
    chk("r0_addr16", ad_a16, 21'h000000);
    chk("r0_oe_early", oe_a8, 0);
    ack_second(8'h41);
    chk("r0_oe", oe_a8, 1);
    chk("r0_d", d_a8, 8'h41);
    chk("r0_rq_off", rq_a8, 0);
    @(negedge clk21m);
    chk("r0_hold_oe", oe_a8, 1);
    chk("r0_hold_d", d_a8, 8'h41);
    rd_end();
    chk("r0_end_oe", oe_a8, 0);
    chk("r0_end_d", d_a8, 8'hFF);

    // Bank switching, ASCII8 then ASCII16
    bus_write(16'h7000, 8'h05);
    rd_begin(16'h8123);
    chk("a8_addr", ad_a8, 21'h00A123);
    chk("msk_addr5", ad_msk, 21'h00A123);
    ack_second(8'h11);
    chk("a8_d", d_a8, 8'h11);
    rd_end();
    bus_write(16'h7000, 8'h03);
    rd_begin(16'h8123);
    chk("a16_addr", ad_a16, 21'h00C123);
    chk("a8_addr3", ad_a8, 21'h006123);
    ack_second(8'h22);
    chk("a16_d", d_a16, 8'h22);
    chk("a16_oe", oe_a16, 1);
    rd_end();

    // Bank mask wrap
    bus_write(16'h6800, 8'h13);
    rd_begin(16'h6010);
    chk("msk_addr", ad_msk, 21'h006010);
    chk("msk_a8_addr", ad_a8, 21'h026010);
    chk("msk_a16_addr", ad_a16, 21'h002010);
    ack_second(8'h77);
    chk("msk_d", d_msk, 8'h77);
    rd_end();

    // Unselected slot and out-of-window reads
    slot_sel = 1'b0;
    cpu_addr = 16'h4000; cpu_mreq = 1'b1; cpu_rd = 1'b1;
    repeat (3) @(negedge clk21m);
    chk("nosel_rq", rq_a8, 0);
    chk("nosel_oe", oe_a8, 0);
    rd_end();
    slot_sel = 1'b1;
    cpu_addr = 16'hC000; cpu_mreq = 1'b1; cpu_rd = 1'b1;
    repeat (3) @(negedge clk21m);
    chk("win_rq", rq_a8, 0);
    chk("win_oe", oe_a8, 0);
    rd_end();

    // Simultaneous rd and wr: read ignored
    cpu_addr = 16'h4000; cpu_mreq = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b1;
    repeat (2) @(negedge clk21m);
    chk("rdwr_rq", rq_a8, 0);
    cpu_wr = 1'b0;
    rd_end();

    // Abort: read dropped during REQ, late ack discarded
    rd_begin(16'h4000);
    chk("ab_rq", rq_a8, 1);
    cpu_rd = 1'b0; cpu_mreq = 1'b0;
    repeat (3) @(negedge clk21m);
    chk("ab_rq_held", rq_a8, 1);
    mem_ack = 1'b1; mem_rdata = 8'h99;
    @(negedge clk21m);
    mem_ack = 1'b0;
    chk("ab_oe", oe_a8, 0);
    chk("ab_d", d_a8, 8'hFF);
    chk("ab_rq_off", rq_a8, 0);
    @(negedge clk21m);
    chk("ab_oe2", oe_a8, 0);
    rd_begin(16'h4000);
    chk("ab_next_rq", rq_a8, 1);
    ack_second(8'h42);
    chk("ab_next_oe", oe_a8, 1);
    chk("ab_next_d", d_a8, 8'h42);
    rd_end();
    chk("ab_next_end", oe_a8, 0);

    // SRAM mapping of bank2
    bus_write(16'h7000, 8'h80);
`ifdef CART_SRAM_EN
    cpu_addr = 16'h8010; cpu_dout = 8'h5A; cpu_mreq = 1'b1; cpu_wr = 1'b1;
    @(negedge clk21m);
    cpu_wr = 1'b0; cpu_mreq = 1'b0;
    chk("sw_wq", wq_a8, 1);
    chk("sw_sram", sr_a8, 1);
    chk("sw_addr", ad_a8, 21'h000010);
    chk("sw_wdata", wd_a8, 8'h5A);
    chk("sw_oe", oe_a8, 0);
    chk("sw_a16_wq", wq_a16, 0);
    mem_ack = 1'b1;
    @(negedge clk21m);
    mem_ack = 1'b0;
    chk("sw_wq_off", wq_a8, 0);
    chk("sw_oe2", oe_a8, 0);
    rd_begin(16'h8010);
    chk("sr_rq", rq_a8, 1);
    chk("sr_sram", sr_a8, 1);
    chk("sr_addr", ad_a8, 21'h000010);
    ack_second(8'h3C);
    chk("sr_oe", oe_a8, 1);
    chk("sr_d", d_a8, 8'h3C);
    rd_end();
`else
    bus_write(16'h8010, 8'h5A);
    chk("nsw_wq", wq_a8, 0);
    chk("nsw_sram", sr_a8, 0);
    rd_begin(16'h8010);
    chk("nsr_addr", ad_a8, 21'h100010);
    chk("nsr_sram", sr_a8, 0);
    ack_second(8'h3C);
    chk("nsr_d", d_a8, 8'h3C);
    rd_end();
`endif

    // Reset in the middle of a request, stray ack afterwards
    rd_begin(16'h4000);
    chk("mr_rq", rq_a8, 1);
    #2 reset_n = 1'b0;
    #1 chk("mr_rst_rq", rq_a8, 0);
    chk("mr_rst_addr", ad_a8, 0);
    @(negedge clk21m);
    cpu_rd = 1'b0; cpu_mreq = 1'b0; reset_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    @(negedge clk21m);
    mem_ack = 1'b0;
    chk("mr_oe", oe_a8, 0);
    chk("mr_d", d_a8, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
